// File: rtl/cbfp_pkg.sv
// Shared definitions for the convergent block-floating-point stream normaliser.
package cbfp_pkg;

  localparam int unsigned DEF_IN_W      = 23;
  localparam int unsigned DEF_OUT_W     = 12;
  localparam int unsigned DEF_LANES     = 16;
  localparam int unsigned DEF_BLOCK_LEN = 64;
  localparam int unsigned DEF_IDX_W     = $clog2(DEF_IN_W);
  localparam int unsigned BEATS         = DEF_BLOCK_LEN / DEF_LANES;

  typedef logic [DEF_LANES*DEF_IN_W-1:0]  lanes_in_t;
  typedef logic [DEF_LANES*DEF_OUT_W-1:0] lanes_out_t;
  typedef logic [DEF_IDX_W-1:0]           idx_t;

  // Redundant sign bits of the low w bits of x (bits below the MSB equal to it).
  function automatic logic [7:0] lsc(input logic [63:0] x, input int unsigned w);
    logic [7:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int unsigned i = 1; i < 64; i++) begin
      if (i < w && run) begin
        if (x[6'(w-1-i)] == x[6'(w-1)]) n = n + 8'd1;
        else                            run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/cbfp_lsc_min.sv
// Minimum redundant-sign count over all re/im lanes of one beat (combinational).
module cbfp_lsc_min
  import cbfp_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned IDX_W = $clog2(IN_W)
) (
  input  logic [LANES*IN_W-1:0] i_re,
  input  logic [LANES*IN_W-1:0] i_im,
  output logic [IDX_W-1:0]      o_min
);

  localparam int unsigned N  = 2 * LANES;
  localparam int unsigned NP = 1 << $clog2(N);
  localparam int unsigned LV = $clog2(NP);

  // Leaves beyond 2*LANES are padded with the largest count so they never win.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int unsigned W = NP >> l;
    logic [IDX_W-1:0] v [W];
    for (genvar j = 0; j < W; j++) begin : g_n
      if (l == 0) begin : g_leaf
        if (j < LANES) begin : g_re
          assign v[j] = IDX_W'(lsc(64'(i_re[j*IN_W +: IN_W]), IN_W));
        end else if (j < N) begin : g_im
          assign v[j] = IDX_W'(lsc(64'(i_im[(j-LANES)*IN_W +: IN_W]), IN_W));
        end else begin : g_pad
          assign v[j] = IDX_W'(IN_W - 1);
        end
      end else begin : g_node
        assign v[j] = (g_lvl[l-1].v[2*j] < g_lvl[l-1].v[2*j+1]) ?
                      g_lvl[l-1].v[2*j] : g_lvl[l-1].v[2*j+1];
      end
    end
  end

  assign o_min = g_lvl[LV].v[0];

endmodule

// File: rtl/cbfp_stream.sv
// Streaming CBFP normaliser: ping-pong block buffers, one shared shift per block,
// registered AXI-style output stage.
module cbfp_stream
  import cbfp_pkg::*;
#(
  parameter int unsigned IN_W      = DEF_IN_W,
  parameter int unsigned OUT_W     = DEF_OUT_W,
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int unsigned MAX_SHIFT = IN_W - 1,
  parameter int unsigned IDX_W     = $clog2(IN_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_bypass,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_re,
  input  logic [LANES*IN_W-1:0]  in_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_re,
  output logic [LANES*OUT_W-1:0] out_im,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_first,
  output logic                   out_last
);

  localparam int unsigned NB = BLOCK_LEN / LANES;
  localparam int unsigned CW = $clog2(NB);
  localparam int unsigned DW = LANES * IN_W;
  localparam int unsigned QW = LANES * OUT_W;

  logic [DW-1:0]    r_mem_re [2][NB];
  logic [DW-1:0]    r_mem_im [2][NB];
  logic [IDX_W-1:0] r_shift  [2];
  logic [1:0]       r_byp;
  logic [1:0]       r_full;
  logic             r_wbuf, r_rbuf;
  logic [CW-1:0]    r_wcnt, r_rcnt;
  logic [IDX_W-1:0] r_run_min;
  logic             r_byp_cur;

  logic [IDX_W-1:0] w_beat_min, w_blk_min, w_shift, w_nidx;
  logic             w_wr, w_wlast, w_blk_byp, w_rd, w_rlast, w_nrbuf, w_nvalid;
  logic [1:0]       w_nfull;
  logic [CW-1:0]    w_nrcnt;
  logic [DW-1:0]    w_src_re, w_src_im;
  logic [QW-1:0]    w_sc_re, w_sc_im;

  function automatic logic [OUT_W-1:0] scale(input logic [IN_W-1:0] x,
                                             input logic [IDX_W-1:0] s);
    return OUT_W'((x << s) >> (IN_W - OUT_W));
  endfunction

  cbfp_lsc_min #(.IN_W(IN_W), .LANES(LANES), .IDX_W(IDX_W)) u_lsc_min (
    .i_re  (in_re),
    .i_im  (in_im),
    .o_min (w_beat_min)
  );

  assign in_ready = !r_full[r_wbuf];

  always_comb begin
    w_wr      = in_valid & in_ready;
    w_wlast   = w_wr && (r_wcnt == CW'(NB - 1));
    w_blk_min = (r_wcnt == '0 || w_beat_min < r_run_min) ? w_beat_min : r_run_min;
    w_blk_byp = (r_wcnt == '0) ? cfg_bypass : r_byp_cur;
    w_shift   = (w_blk_min > IDX_W'(MAX_SHIFT)) ? IDX_W'(MAX_SHIFT) : w_blk_min;
    w_rd      = out_valid & out_ready;
    w_rlast   = w_rd && (r_rcnt == CW'(NB - 1));
    w_nfull   = r_full;
    if (w_wlast) w_nfull[r_wbuf] = 1'b1;
    if (w_rlast) w_nfull[r_rbuf] = 1'b0;
    w_nrbuf   = r_rbuf ^ w_rlast;
    w_nrcnt   = w_rlast ? '0 : (w_rd ? r_rcnt + CW'(1) : r_rcnt);
    w_nvalid  = w_nfull[w_nrbuf];
  end

  // The output register is loaded from the post-edge read position, so a block
  // finalised on this edge must take its shift from the write side directly.
  always_comb begin
    w_nidx = r_byp[w_nrbuf] ? '0 : r_shift[w_nrbuf];
    if (w_wlast && (r_wbuf == w_nrbuf)) w_nidx = w_blk_byp ? '0 : w_shift;
    w_src_re = r_mem_re[w_nrbuf][w_nrcnt];
    w_src_im = r_mem_im[w_nrbuf][w_nrcnt];
    w_sc_re  = '0;
    w_sc_im  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_sc_re[k*OUT_W +: OUT_W] = scale(w_src_re[k*IN_W +: IN_W], w_nidx);
      w_sc_im[k*OUT_W +: OUT_W] = scale(w_src_im[k*IN_W +: IN_W], w_nidx);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_re[r_wbuf][r_wcnt] <= in_re;
      r_mem_im[r_wbuf][r_wcnt] <= in_im;
      r_run_min                <= w_blk_min;
      if (r_wcnt == '0) r_byp_cur <= cfg_bypass;
    end
    if (w_wlast) begin
      r_shift[r_wbuf] <= w_shift;
      r_byp[r_wbuf]   <= w_blk_byp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_wbuf    <= 1'b0;
      r_rbuf    <= 1'b0;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      r_full    <= w_nfull;
      r_wbuf    <= r_wbuf ^ w_wlast;
      r_wcnt    <= w_wlast ? '0 : (w_wr ? r_wcnt + CW'(1) : r_wcnt);
      r_rbuf    <= w_nrbuf;
      r_rcnt    <= w_nrcnt;
      out_valid <= w_nvalid;
      out_re    <= w_nvalid ? w_sc_re : '0;
      out_im    <= w_nvalid ? w_sc_im : '0;
      out_idx   <= w_nvalid ? w_nidx : '0;
      out_first <= w_nvalid && (w_nrcnt == '0);
      out_last  <= w_nvalid && (w_nrcnt == CW'(NB - 1));
    end
  end

endmodule

// File: tb/tb_cbfp_stream.sv
// Scoreboard bench for cbfp_stream: directed blocks plus a random stream.
module tb_cbfp_stream;
  import cbfp_pkg::*;

  localparam int IN_W  = 23;
  localparam int OUT_W = 12;
  localparam int LANES = 16;
  localparam int BL    = 64;
  localparam int MAXS  = 22;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_bypass = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  lanes_in_t  in_re = '0;
  lanes_in_t  in_im = '0;
  logic       in_ready, out_valid, out_first, out_last;
  lanes_out_t out_re, out_im;
  idx_t       out_idx;

  cbfp_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .BLOCK_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_bypass (cfg_bypass),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_idx    (out_idx),
    .out_first  (out_first),
    .out_last   (out_last)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    lanes_out_t re;
    lanes_out_t im;
    idx_t       idx;
    logic       first;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rnd_mode = 1'b0;

  logic signed [IN_W-1:0] blk_re [BL];
  logic signed [IN_W-1:0] blk_im [BL];
  logic [OUT_W-1:0]       er [BL];
  logic [OUT_W-1:0]       ei [BL];
  idx_t                   e_idx;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_lsc(input logic signed [IN_W-1:0] x);
    longint lim;
    for (int s = IN_W - 1; s >= 0; s--) begin
      lim = longint'(1) << (IN_W - 1 - s);
      if (longint'(x) >= -lim && longint'(x) < lim) return s;
    end
    return 0;
  endfunction

  function automatic logic [OUT_W-1:0] m_scale(input logic signed [IN_W-1:0] x, input int s);
    longint v;
    v = longint'(x) <<< s;
    v = v >>> (IN_W - OUT_W);
    return v[OUT_W-1:0];
  endfunction

  task automatic model_block(input bit byp);
    int mn, s;
    mn = IN_W - 1;
    for (int i = 0; i < BL; i++) begin
      if (m_lsc(blk_re[i]) < mn) mn = m_lsc(blk_re[i]);
      if (m_lsc(blk_im[i]) < mn) mn = m_lsc(blk_im[i]);
    end
    s = byp ? 0 : ((mn > MAXS) ? MAXS : mn);
    e_idx = idx_t'(s);
    for (int i = 0; i < BL; i++) begin
      er[i] = m_scale(blk_re[i], s);
      ei[i] = m_scale(blk_im[i], s);
    end
  endtask

  task automatic fill(input logic signed [IN_W-1:0] vre, input logic signed [IN_W-1:0] vim,
                      input logic [OUT_W-1:0] xre, input logic [OUT_W-1:0] xim, input idx_t idx);
    for (int i = 0; i < BL; i++) begin
      blk_re[i] = vre;
      blk_im[i] = vim;
      er[i]     = xre;
      ei[i]     = xim;
    end
    e_idx = idx;
  endtask

  task automatic push_exp();
    exp_t e;
    for (int b = 0; b < BEATS; b++) begin
      for (int k = 0; k < LANES; k++) begin
        e.re[k*OUT_W +: OUT_W] = er[b*LANES + k];
        e.im[k*OUT_W +: OUT_W] = ei[b*LANES + k];
      end
      e.idx   = e_idx;
      e.first = (b == 0);
      e.last  = (b == BEATS - 1);
      q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
  task automatic send_block(input int nb, input bit byp0, input bit byp_rest,
                            input int maxgap, input bit lat);
    int w;
    for (int b = 0; b < nb; b++) begin
      repeat ((maxgap > 0) ? $urandom_range(0, maxgap) : 0) begin
        in_valid   = 1'b0;
        in_re      = {LANES{23'($urandom)}};
        cfg_bypass = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid   = 1'b1;
      cfg_bypass = (b == 0) ? byp0 : byp_rest;
      for (int k = 0; k < LANES; k++) begin
        in_re[k*IN_W +: IN_W] = blk_re[b*LANES + k];
        in_im[k*IN_W +: IN_W] = blk_im[b*LANES + k];
      end
      w = 0;
      while (!in_ready && w < 2000) begin
        @(posedge clk); #1;
        w++;
      end
      if (!in_ready) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout: in_ready=0 expected 1 within 2000 cycles");
        in_valid = 1'b0;
        return;
      end
      if (b == nb - 1 && nb == BEATS) begin
        if (lat) chk("latency_before_last", 256'(out_valid), 256'(1'b0));
        push_exp();
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 5000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_pending_beats", 256'(q.size()), 256'(0));
  endtask

  // Monitor: pops on every output handshake, checks hold while stalled.
  initial begin
    exp_t       e;
    bit         stall;
    lanes_out_t p_re, p_im;
    logic [6:0] p_ctl;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_re", 256'(out_re), 256'(p_re));
          chk("hold_im", 256'(out_im), 256'(p_im));
          chk("hold_ctl", 256'({out_idx, out_first, out_last}), 256'(p_ctl));
        end
        if (out_ready) begin
          stall = 1'b0;
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got idx=%0d first=%0b expected no beat", out_idx, out_first);
          end else begin
            e = q.pop_front();
            chk("out_re", 256'(out_re), 256'(e.re));
            chk("out_im", 256'(out_im), 256'(e.im));
            chk("out_idx", 256'(out_idx), 256'(e.idx));
            chk("out_first", 256'(out_first), 256'(e.first));
            chk("out_last", 256'(out_last), 256'(e.last));
          end
        end else begin
          stall = 1'b1;
          p_re  = out_re;
          p_im  = out_im;
          p_ctl = {out_idx, out_first, out_last};
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_mode) out_ready = 1'($urandom);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: still running at 1000000 ns expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, wmax, wi;
    bit byp0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
    chk("rst_out_idx", 256'(out_idx), 256'(0));
    chk("rst_first_last", 256'({out_first, out_last}), 256'(2'b00));
    chk("rst_out_re", 256'(out_re), 256'(0));
    out_ready = 1'b1;

    // 1024 -> shift 11, value preserved; output one cycle after last input beat
    fill(23'sd1024, 23'sd1024, 12'd1024, 12'd1024, idx_t'(11));
    send_block(BEATS, 1'b0, 1'b0, 0, 1'b1);
    chk("latency_after_last", 256'(out_valid), 256'(1'b1));
    chk("latency_first", 256'(out_first), 256'(1'b1));
    drain();

    // one full-scale negative im pins the shift to 0
    fill(23'sd3, 23'sd3, 12'd0, 12'd0, idx_t'(0));
    blk_im[37] = -23'sd4194304;
    ei[37]     = 12'h800;
    send_block(BEATS, 1'b0, 1'b0, 0, 1'b0);
    fill(23'sd3, 23'sd3, 12'd1536, 12'd1536, idx_t'(20));
    send_block(BEATS, 1'b0, 1'b0, 0, 1'b0);
    drain();

    // zero block: clamp to 22; bypass latched only on the first beat
    fill(23'sd0, 23'sd0, 12'd0, 12'd0, idx_t'(22));
    send_block(BEATS, 1'b0, 1'b1, 0, 1'b0);
    fill(23'sd0, 23'sd0, 12'd0, 12'd0, idx_t'(0));
    send_block(BEATS, 1'b1, 1'b0, 0, 1'b0);
    drain();

    // both buffers fill with output stalled, then release
    out_ready = 1'b0;
    fill(23'sd1024, 23'sd1024, 12'd1024, 12'd1024, idx_t'(11));
    send_block(BEATS, 1'b0, 1'b0, 0, 1'b0);
    fill(23'sd3, 23'sd3, 12'd1536, 12'd1536, idx_t'(20));
    send_block(BEATS, 1'b0, 1'b0, 0, 1'b0);
    chk("both_full_in_ready", 256'(in_ready), 256'(1'b0));
    fill(-23'sd1, -23'sd1, 12'h800, 12'h800, idx_t'(22));
    fork
      send_block(BEATS, 1'b0, 1'b0, 0, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("stall_out_valid", 256'(out_valid), 256'(1'b1));
        chk("stall_in_ready", 256'(in_ready), 256'(1'b0));
        out_ready = 1'b1;
      end
    join
    drain();

    // random stream against the model
    rnd_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      wmax = $urandom_range(0, IN_W);
      for (int i = 0; i < BL; i++) begin
        wi = (wmax == 0) ? 0 : $urandom_range(1, wmax);
        t  = $urandom;
        t  = (wi == 0) ? 0 : ((t <<< (32 - wi)) >>> (32 - wi));
        blk_re[i] = t[IN_W-1:0];
        t  = $urandom;
        t  = (wi == 0) ? 0 : ((t <<< (32 - wi)) >>> (32 - wi));
        blk_im[i] = t[IN_W-1:0];
      end
      byp0 = ($urandom_range(0, 7) == 0);
      model_block(byp0);
      send_block(BEATS, byp0, 1'($urandom), 2, 1'b0);
    end
    drain();
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    drain();

    // reset mid-block discards the partial block
    fill(-23'sd4194304, -23'sd4194304, 12'd0, 12'd0, idx_t'(0));
    send_block(2, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("midrst_in_ready", 256'(in_ready), 256'(1'b1));
    fill(23'sd1024, 23'sd1024, 12'd1024, 12'd1024, idx_t'(11));
    send_block(BEATS, 1'b0, 1'b0, 0, 1'b0);
    drain();
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
